// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine writing the HI/LO pair.
// A start pulse in IDLE latches operand magnitudes and result signs. CALC then
// runs WIDTH iterations: a radix-2 shift-add for multiply, or restoring
// division for divide. FIX applies the sign corrections and writes HI/LO.
// Ports:
//   clk, rst_n          clock and async active-low reset
//   start, op, a, b     operation request (op: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV)
//   hi_we, lo_we, wdata MTHI/MTLO writes, honoured only in IDLE
//   busy, done          operation in flight / one-cycle result pulse (registered)
//   hi, lo              architectural HI/LO registers
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam int DW    = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

    state_t             state_r, state_nxt_s;
    logic [1:0]         op_r, op_nxt_s;
    logic [WIDTH-1:0]   opnd_r, opnd_nxt_s;   // multiplicand or divisor magnitude
    logic [DW-1:0]      acc_r, acc_nxt_s;     // {partial product | remainder, multiplier | quotient}
    logic               neg_lo_r, neg_lo_nxt_s;
    logic               neg_rem_r, neg_rem_nxt_s;
    logic               dz_r, dz_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic [WIDTH-1:0]   hi_r, hi_nxt_s;
    logic [WIDTH-1:0]   lo_r, lo_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic               done_r, done_nxt_s;

    // Magnitude of v, taken only when the operation is signed.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic sgn);
        logic [WIDTH-1:0] r;
        if (sgn && v[WIDTH-1]) begin
            r = ~v + WIDTH'(1);
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Multiply step: add the multiplicand when the low multiplier bit is set, then shift right.
    logic [WIDTH:0]   mul_sum_s;
    logic [DW-1:0]    mul_step_s;
    assign mul_sum_s  = {1'b0, acc_r[DW-1:WIDTH]} + {1'b0, (acc_r[0] ? opnd_r : {WIDTH{1'b0}})};
    assign mul_step_s = {mul_sum_s, acc_r[WIDTH-1:1]};

    // Divide step: shift the next dividend bit into the remainder, subtract if it fits.
    // A zero divisor always fits, which yields all-ones quotient and remainder = dividend.
    logic [WIDTH:0]   div_sh_s, div_diff_s;
    logic             div_ok_s;
    logic [DW-1:0]    div_step_s;
    assign div_sh_s   = {acc_r[DW-1:WIDTH], acc_r[WIDTH-1]};
    assign div_diff_s = div_sh_s - {1'b0, opnd_r};
    assign div_ok_s   = ~div_diff_s[WIDTH];
    assign div_step_s = {(div_ok_s ? div_diff_s[WIDTH-1:0] : div_sh_s[WIDTH-1:0]),
                         acc_r[WIDTH-2:0], div_ok_s};

    // Sign-corrected results used in FIX.
    logic [DW-1:0]    prod_fix_s;
    logic [WIDTH-1:0] quo_fix_s, rem_fix_s;
    assign prod_fix_s = neg_lo_r ? (~acc_r + DW'(1)) : acc_r;
    assign quo_fix_s  = dz_r ? {WIDTH{1'b1}}
                             : (neg_lo_r ? (~acc_r[WIDTH-1:0] + WIDTH'(1)) : acc_r[WIDTH-1:0]);
    assign rem_fix_s  = neg_rem_r ? (~acc_r[DW-1:WIDTH] + WIDTH'(1)) : acc_r[DW-1:WIDTH];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = start ? CALC : IDLE;
            CALC:    state_nxt_s = (cnt_r == {CNT_W{1'b0}}) ? FIX : CALC;
            FIX:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        op_nxt_s      = op_r;
        opnd_nxt_s    = opnd_r;
        acc_nxt_s     = acc_r;
        neg_lo_nxt_s  = neg_lo_r;
        neg_rem_nxt_s = neg_rem_r;
        dz_nxt_s      = dz_r;
        cnt_nxt_s     = cnt_r;
        hi_nxt_s      = hi_r;
        lo_nxt_s      = lo_r;
        busy_nxt_s    = (state_nxt_s != IDLE);
        done_nxt_s    = (state_r == FIX);
        case (state_r)
            IDLE: begin
                if (hi_we) begin
                    hi_nxt_s = wdata;
                end else begin
                    hi_nxt_s = hi_r;
                end
                if (lo_we) begin
                    lo_nxt_s = wdata;
                end else begin
                    lo_nxt_s = lo_r;
                end
                if (start) begin
                    op_nxt_s      = op;
                    opnd_nxt_s    = op[1] ? abs_val(b, op[0]) : abs_val(a, op[0]);
                    acc_nxt_s     = {{WIDTH{1'b0}}, (op[1] ? abs_val(a, op[0]) : abs_val(b, op[0]))};
                    neg_lo_nxt_s  = op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_nxt_s = op[0] & a[WIDTH-1];
                    dz_nxt_s      = op[1] & (b == {WIDTH{1'b0}});
                    cnt_nxt_s     = CNT_W'(WIDTH - 1);
                end else begin
                    op_nxt_s      = op_r;
                end
            end
            CALC: begin
                acc_nxt_s = op_r[1] ? div_step_s : mul_step_s;
                cnt_nxt_s = cnt_r - CNT_W'(1);
            end
            FIX: begin
                if (op_r[1]) begin
                    hi_nxt_s = rem_fix_s;
                    lo_nxt_s = quo_fix_s;
                end else begin
                    hi_nxt_s = prod_fix_s[DW-1:WIDTH];
                    lo_nxt_s = prod_fix_s[WIDTH-1:0];
                end
            end
            default: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r      <= 2'b00;
            opnd_r    <= {WIDTH{1'b0}};
            acc_r     <= {DW{1'b0}};
            neg_lo_r  <= 1'b0;
            neg_rem_r <= 1'b0;
            dz_r      <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            op_r      <= op_nxt_s;
            opnd_r    <= opnd_nxt_s;
            acc_r     <= acc_nxt_s;
            neg_lo_r  <= neg_lo_nxt_s;
            neg_rem_r <= neg_rem_nxt_s;
            dz_r      <= dz_nxt_s;
            cnt_r     <= cnt_nxt_s;
            hi_r      <= hi_nxt_s;
            lo_r      <= lo_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: issue pushes expected HI/LO and done cycle,
// a negedge monitor pops and compares whenever done is high.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = 32'h0, b = 32'h0, wdata = 32'h0;
    logic        hi_we = 1'b0, lo_we = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compare each done pulse against the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_hi"}, {32'h0, hi}, {32'h0, e.hi});
                chk({e.name, "_lo"}, {32'h0, lo}, {32'h0, e.lo});
                chk({e.name, "_cyc"}, 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Drive a start at the current negedge; result due 33 edges after the sampling edge.
    task automatic issue(input string name, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                         input logic push);
        exp_t e;
        start = 1'b1; op = o; a = x; b = y;
        e.hi = eh; e.lo = el; e.cyc = cyc + 1 + 33; e.name = name;
        if (push) sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait at negedges until busy drops; bounded.
    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk({name, "_timeout"}, 64'd1, 64'd0);
    endtask

    initial begin
        int n;
        #12;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_hi", {32'h0, hi}, 64'd0);
        chk("rst_lo", {32'h0, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // MULTU max*max, with busy width measured
        issue("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("busy_len", 64'(n), 64'd33);

        // MULT -3*7, then DIV -7/2 issued in the done cycle
        @(negedge clk);
        issue("mult_neg", 2'b01, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1);
        wait_idle("mult_neg");
        issue("div_neg", 2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1);
        wait_idle("div_neg");

        issue("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
        wait_idle("divu_100_7");
        issue("divu_zero", 2'b10, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 1'b1);
        wait_idle("divu_zero");
        issue("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b1);
        wait_idle("div_ovf");
        issue("div_zero_neg", 2'b11, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1);
        wait_idle("div_zero_neg");
        @(negedge clk);

        // MTHI in IDLE
        hi_we = 1'b1; wdata = 32'hAAAA5555;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi", {32'h0, hi}, {32'h0, 32'hAAAA5555});

        // MULTU 3*4 with MTLO in the same cycle
        lo_we = 1'b1; wdata = 32'h0000DEAD;
        issue("multu_3_4", 2'b00, 32'd3, 32'd4, 32'h0, 32'd12, 1'b1);
        lo_we = 1'b0;
        chk("mtlo_same", {32'h0, lo}, {32'h0, 32'h0000DEAD});
        repeat (20) @(negedge clk);
        chk("mtlo_hold_lo", {32'h0, lo}, {32'h0, 32'h0000DEAD});
        chk("mtlo_hold_hi", {32'h0, hi}, {32'h0, 32'hAAAA5555});
        wait_idle("multu_3_4");
        @(negedge clk);

        // start and MTHI while busy are ignored
        issue("multu_5_6", 2'b00, 32'd5, 32'd6, 32'h0, 32'd30, 1'b1);
        repeat (3) @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'd9; b = 32'd3; hi_we = 1'b1; wdata = 32'h11111111;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        chk("busy_mthi_ignored", {32'h0, hi}, 64'd0);
        wait_idle("multu_5_6");
        repeat (3) @(negedge clk);
        chk("no_extra_busy", {63'd0, busy}, 64'd0);

        // async reset mid-CALC
        issue("aborted", 2'b00, 32'd7, 32'd7, 32'h0, 32'd49, 1'b0);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_hi", {32'h0, hi}, 64'd0);
        chk("abort_lo", {32'h0, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue("multu_2_3", 2'b00, 32'd2, 32'd3, 32'h0, 32'd6, 1'b1);
        wait_idle("multu_2_3");
        repeat (3) @(negedge clk);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
